bin_tape_punch: RTL

//  Dump engine that reads a PDP-8 memory range and emits it as a BIN-loader byte stream.

---
 rtl/bin_tape_punch.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bin_tape_punch.sv
// rtl/bin_tape_punch.sv - PDP-8 memory range to BIN-loader byte stream dump engine
// Optional checksum frame enabled by defining BIN_CHECKSUM_EN.
module bin_tape_punch #(
  parameter int LEADER_LEN  = 16,
  parameter int TRAILER_LEN = 16
) (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic        start,
  input  logic [11:0] start_addr,
  input  logic [11:0] end_addr,
  output logic [11:0] mem_addr,
  output logic        mem_rd_en,
  input  logic        mem_rd_valid,
  input  logic [11:0] mem_rd_data,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEADER,
    S_ORG_HI,
    S_ORG_LO,
    S_RD_REQ,
    S_RD_WAIT,
    S_DAT_HI,
    S_DAT_LO,
`ifdef BIN_CHECKSUM_EN
    S_CSUM_HI,
    S_CSUM_LO,
`endif
    S_TRAILER,
    S_DONE
  } state_t;

  localparam logic [7:0]  FEED_BYTE = 8'o200;
  localparam logic [15:0] LEAD_LAST = 16'(LEADER_LEN - 1);
  localparam logic [15:0] TRL_LAST  = 16'(TRAILER_LEN - 1);

  state_t      state, state_nx;
  state_t      tail_state;
  logic [11:0] start_q;
  logic [11:0] end_q;
  logic [11:0] cur;
  logic [11:0] word;
  logic [15:0] cnt;
  logic        accept;
`ifdef BIN_CHECKSUM_EN
  logic [11:0] csum;
`endif

  assign accept = byte_valid && byte_ready;

  always_comb begin
    state_nx   = state;
    byte_valid = 1'b0;
    byte_out   = 8'h00;
    mem_rd_en  = 1'b0;
    mem_addr   = 12'h000;
    busy       = 1'b1;
    done       = 1'b0;
    tail_state = (TRAILER_LEN > 0) ? S_TRAILER : S_DONE;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (LEADER_LEN > 0) ? S_LEADER : S_ORG_HI;
      end
      S_LEADER: begin
        byte_valid = 1'b1;
        byte_out   = FEED_BYTE;
        if (byte_ready && cnt == LEAD_LAST) state_nx = S_ORG_HI;
      end
      S_ORG_HI: begin
        byte_valid = 1'b1;
        byte_out   = {2'b01, start_q[11:6]};
        if (byte_ready) state_nx = S_ORG_LO;
      end
      S_ORG_LO: begin
        byte_valid = 1'b1;
        byte_out   = {2'b00, start_q[5:0]};
        if (byte_ready) state_nx = S_RD_REQ;
      end
      S_RD_REQ: begin
        mem_rd_en = 1'b1;
        mem_addr  = cur;
        state_nx  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_rd_valid) state_nx = S_DAT_HI;
      end
      S_DAT_HI: begin
        byte_valid = 1'b1;
        byte_out   = {2'b00, word[11:6]};
        if (byte_ready) state_nx = S_DAT_LO;
      end
      S_DAT_LO: begin
        byte_valid = 1'b1;
        byte_out   = {2'b00, word[5:0]};
        // The range is inclusive, so the word at end_q is the final one even after wrap.
        if (byte_ready) begin
`ifdef BIN_CHECKSUM_EN
          state_nx = (cur == end_q) ? S_CSUM_HI : S_RD_REQ;
`else
          state_nx = (cur == end_q) ? tail_state : S_RD_REQ;
`endif
        end
      end
`ifdef BIN_CHECKSUM_EN
      S_CSUM_HI: begin
        byte_valid = 1'b1;
        byte_out   = {2'b00, csum[11:6]};
        if (byte_ready) state_nx = S_CSUM_LO;
      end
      S_CSUM_LO: begin
        byte_valid = 1'b1;
        byte_out   = {2'b00, csum[5:0]};
        if (byte_ready) state_nx = tail_state;
      end
`endif
      S_TRAILER: begin
        byte_valid = 1'b1;
        byte_out   = FEED_BYTE;
        if (byte_ready && cnt == TRL_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state   <= S_IDLE;
      start_q <= 12'h000;
      end_q   <= 12'h000;
      cur     <= 12'h000;
      word    <= 12'h000;
      cnt     <= 16'h0000;
`ifdef BIN_CHECKSUM_EN
      csum    <= 12'h000;
`endif
    end else begin
      state <= state_nx;

      // Feed counter restarts on every state change, so leader and trailer share it.
      if (state_nx != state) cnt <= 16'h0000;
      else if (accept)       cnt <= cnt + 16'h0001;

      if (state == S_IDLE && start) begin
        start_q <= start_addr;
        end_q   <= end_addr;
        cur     <= start_addr;
      end

      if (state == S_RD_WAIT && mem_rd_valid) word <= mem_rd_data;

      if (state == S_DAT_LO && accept) cur <= cur + 12'h001;

`ifdef BIN_CHECKSUM_EN
      if (state == S_IDLE && start) begin
        csum <= 12'h000;
      end else if (accept && (state == S_ORG_HI || state == S_ORG_LO ||
                              state == S_DAT_HI || state == S_DAT_LO)) begin
        csum <= csum + {4'h0, byte_out};
      end
`endif
    end
  end

endmodule
